serial_adder_16: RTL and testbench

Bit-serial add/subtract unit for the 16-bit CPU datapath. It holds two operands in shift registers and pushes one bit pair per clock through a single full-adder cell, with the carry kept in a flip-flop. It returns the registered sum and status flags after WIDTH cycles. It sits between the register file read ports and the writeback/flags stage, and serves as the area-minimal alternative to the ripple-carry adder.

---
 rtl/serial_adder_16_if.sv | 28 ++
 rtl/serial_adder_16.sv | 132 +++++++++++++
 tb/tb_serial_adder_16.sv | 307 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/serial_adder_16_if.sv
// serial_adder_16 request/result bundle.
// master drives operands and Start; slave returns status and result.
interface serial_adder_16_if #(
  parameter int WIDTH = 16
);
  logic             Start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Cin;
  logic             Sub;
  logic             Busy;
  logic             Done;
  logic [WIDTH-1:0] Sum;
  logic             Cout;
  logic             Ovf;
  logic             Zero;
  logic             Neg;

  modport master (
    output Start, A, B, Cin, Sub,
    input  Busy, Done, Sum, Cout, Ovf, Zero, Neg
  );

  modport slave (
    input  Start, A, B, Cin, Sub,
    output Busy, Done, Sum, Cout, Ovf, Zero, Neg
  );
endinterface

// File: rtl/serial_adder_16.sv
// Bit-serial add/subtract unit: one full-adder cell, WIDTH cycles per op.
// Optional subtract path enabled by defining SERIAL_ADDER_SUB_EN.
module serial_adder_16 #(
  parameter int WIDTH = 16
) (
  input logic         clk,
  input logic         rst_n,
  serial_adder_16_if.slave bus
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state;
  state_t state_nx;

  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [WIDTH-1:0] sr;
  logic             c;
  logic [CW-1:0]    cnt;

  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
  logic             zero;
  logic             neg;

  logic             accept;
  logic             last;
  logic             s;
  logic             c_nx;
  logic [WIDTH-1:0] res;
  logic [WIDTH-1:0] sb_ld;
  logic             c_ld;

`ifdef SERIAL_ADDER_SUB_EN
  assign sb_ld = bus.Sub ? ~bus.B : bus.B;
  assign c_ld  = bus.Sub | bus.Cin;
`else
  logic sub_unused;
  assign sub_unused = bus.Sub;
  assign sb_ld = bus.B;
  assign c_ld  = bus.Cin;
`endif

  // full-adder cell, new-operand acceptance and final result word
  always_comb begin
    accept = bus.Start &&
             ((state == IDLE) || (state == DONE));
    last   = (cnt == CW'(WIDTH - 1));
    s      = sa[0] ^ sb[0] ^ c;
    c_nx   = (sa[0] & sb[0]) |
             (sa[0] & c) |
             (sb[0] & c);
    res    = {s, sr[WIDTH-1:1]};
  end

  // state register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // next-state decode
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (accept) state_nx = RUN;
      end
      RUN: begin
        if (last) state_nx = DONE;
      end
      DONE: begin
        state_nx = accept ? RUN : IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // operand shifters, carry, counter and result capture
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sa   <= '0;
      sb   <= '0;
      sr   <= '0;
      c    <= 1'b0;
      cnt  <= '0;
      sum  <= '0;
      cout <= 1'b0;
      ovf  <= 1'b0;
      zero <= 1'b1;
      neg  <= 1'b0;
    end else if (accept) begin
      sa  <= bus.A;
      sb  <= sb_ld;
      c   <= c_ld;
      cnt <= '0;
    end else if (state == RUN) begin
      sa  <= sa >> 1;
      sb  <= sb >> 1;
      c   <= c_nx;
      sr  <= res;
      cnt <= cnt + 1'b1;
      if (last) begin
        sum  <= res;
        cout <= c_nx;
        ovf  <= c ^ c_nx;
        zero <= ~|res;
        neg  <= res[WIDTH-1];
      end
    end
  end

  assign bus.Busy = (state == RUN);
  assign bus.Done = (state == DONE);
  assign bus.Sum  = sum;
  assign bus.Cout = cout;
  assign bus.Ovf  = ovf;
  assign bus.Zero = zero;
  assign bus.Neg  = neg;

endmodule

// File: tb/tb_serial_adder_16.sv
// Directed testbench for serial_adder_16.
// Honors SERIAL_ADDER_SUB_EN for the subtract expectations.
module tb_serial_adder_16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  serial_adder_16_if #(.WIDTH(16)) bus ();

  serial_adder_16 #(.WIDTH(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Busy and Done must never overlap
  always @(negedge clk) begin
    if (rst_n) begin
      checks++;
      if (bus.Busy && bus.Done) begin
        errors++;
        $display("FAIL busy_done_overlap busy=%0b done=%0b want not both",
                 bus.Busy, bus.Done);
      end
    end
  end

  task automatic run_op(input logic [15:0] a, input logic [15:0] b,
                        input logic cin, input logic sub,
                        output int cycles, output bit busy_ok);
    @(negedge clk);
    bus.A = a;
    bus.B = b;
    bus.Cin = cin;
    bus.Sub = sub;
    bus.Start = 1'b1;
    @(negedge clk);
    bus.Start = 1'b0;
    cycles = 1;
    busy_ok = 1'b1;
    while (!bus.Done && cycles < 40) begin
      if (!bus.Busy) busy_ok = 1'b0;
      @(negedge clk);
      cycles++;
    end
    if (!bus.Done) cycles = -1;
  endtask

  task automatic test_reset();
    bus.Start = 1'b1;
    bus.A = 16'h1234;
    bus.B = 16'h4321;
    bus.Cin = 1'b0;
    bus.Sub = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (bus.Busy !== 1'b0 || bus.Done !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl busy=%0b done=%0b want 0 0",
               bus.Busy, bus.Done);
    end
    checks++;
    if (bus.Sum !== 16'h0000 || bus.Zero !== 1'b1 ||
        bus.Cout !== 1'b0 || bus.Ovf !== 1'b0 || bus.Neg !== 1'b0) begin
      errors++;
      $display("FAIL reset_res sum=%h z=%b c=%b o=%b n=%b want 0000 1 0 0 0",
               bus.Sum, bus.Zero, bus.Cout, bus.Ovf, bus.Neg);
    end
    bus.Start = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.Busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_nostart busy=%0b want 0", bus.Busy);
    end
  endtask

  task automatic test_add();
    int  cyc;
    bit  bok;
    run_op(16'h1234, 16'h4321, 1'b0, 1'b0, cyc, bok);
    checks++;
    if (cyc !== 17) begin
      errors++;
      $display("FAIL add_latency got=%0d want 17", cyc);
    end
    checks++;
    if (bok !== 1'b1) begin
      errors++;
      $display("FAIL add_busy got=%0b want 1 throughout RUN", bok);
    end
    checks++;
    if (bus.Sum !== 16'h5555 || bus.Cout !== 1'b0 || bus.Ovf !== 1'b0 ||
        bus.Zero !== 1'b0 || bus.Neg !== 1'b0) begin
      errors++;
      $display("FAIL add_result sum=%h c=%b o=%b z=%b n=%b want 5555 0 0 0 0",
               bus.Sum, bus.Cout, bus.Ovf, bus.Zero, bus.Neg);
    end
    @(negedge clk);
    checks++;
    if (bus.Done !== 1'b0) begin
      errors++;
      $display("FAIL add_done_pulse done=%0b want 0", bus.Done);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (bus.Sum !== 16'h5555) begin
      errors++;
      $display("FAIL add_hold sum=%h want 5555", bus.Sum);
    end
  endtask

  task automatic test_wrap();
    int cyc;
    bit bok;
    run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, cyc, bok);
    checks++;
    if (cyc !== 17 || bus.Sum !== 16'h0000 || bus.Cout !== 1'b1 ||
        bus.Ovf !== 1'b0 || bus.Zero !== 1'b1 || bus.Neg !== 1'b0) begin
      errors++;
      $display("FAIL wrap cyc=%0d sum=%h c=%b o=%b z=%b n=%b want 17 0000 1 0 1 0",
               cyc, bus.Sum, bus.Cout, bus.Ovf, bus.Zero, bus.Neg);
    end
  endtask

  task automatic test_overflow();
    int cyc;
    bit bok;
    run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, cyc, bok);
    checks++;
    if (cyc !== 17 || bus.Sum !== 16'h8000 || bus.Cout !== 1'b0 ||
        bus.Ovf !== 1'b1 || bus.Zero !== 1'b0 || bus.Neg !== 1'b1) begin
      errors++;
      $display("FAIL overflow cyc=%0d sum=%h c=%b o=%b z=%b n=%b want 17 8000 0 1 0 1",
               cyc, bus.Sum, bus.Cout, bus.Ovf, bus.Zero, bus.Neg);
    end
  endtask

  task automatic test_cin();
    int cyc;
    bit bok;
    run_op(16'h00FF, 16'h0000, 1'b1, 1'b0, cyc, bok);
    checks++;
    if (bus.Sum !== 16'h0100 || bus.Cout !== 1'b0) begin
      errors++;
      $display("FAIL cin sum=%h c=%b want 0100 0", bus.Sum, bus.Cout);
    end
  endtask

  task automatic test_sub();
    int          cyc;
    bit          bok;
    logic [15:0] want_sum;
    logic        want_neg;
`ifdef SERIAL_ADDER_SUB_EN
    want_sum = 16'hFFFE;
    want_neg = 1'b1;
`else
    want_sum = 16'h000C;
    want_neg = 1'b0;
`endif
    run_op(16'h0005, 16'h0007, 1'b0, 1'b1, cyc, bok);
    checks++;
    if (bus.Sum !== want_sum || bus.Cout !== 1'b0 ||
        bus.Neg !== want_neg) begin
      errors++;
      $display("FAIL sub sum=%h c=%b n=%b want %h 0 %b",
               bus.Sum, bus.Cout, bus.Neg, want_sum, want_neg);
    end
  endtask

  task automatic test_start_in_run();
    int first;
    int ndone;
    @(negedge clk);
    bus.A = 16'h1111;
    bus.B = 16'h2222;
    bus.Cin = 1'b0;
    bus.Sub = 1'b0;
    bus.Start = 1'b1;
    first = -1;
    ndone = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      bus.Start = (k == 8);
      bus.A = (k == 8) ? 16'hAAAA : 16'h1111;
      if (bus.Done) begin
        ndone++;
        if (first < 0) first = k;
      end
    end
    checks++;
    if (first !== 17 || ndone !== 1) begin
      errors++;
      $display("FAIL start_in_run first=%0d ndone=%0d want 17 1",
               first, ndone);
    end
    checks++;
    if (bus.Sum !== 16'h3333) begin
      errors++;
      $display("FAIL start_in_run_sum sum=%h want 3333", bus.Sum);
    end
  endtask

  task automatic test_back_to_back();
    int          first;
    int          second;
    logic [15:0] s1;
    logic [15:0] s2;
    @(negedge clk);
    bus.A = 16'h0001;
    bus.B = 16'h0002;
    bus.Cin = 1'b0;
    bus.Sub = 1'b0;
    bus.Start = 1'b1;
    first = -1;
    second = -1;
    s1 = '0;
    s2 = '0;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (bus.Done) begin
        if (first < 0) begin
          first = k;
          s1 = bus.Sum;
          bus.A = 16'h0003;
          bus.B = 16'h0004;
        end else if (second < 0) begin
          second = k;
          s2 = bus.Sum;
          bus.Start = 1'b0;
        end
      end
    end
    bus.Start = 1'b0;
    checks++;
    if (first !== 17 || second - first !== 17) begin
      errors++;
      $display("FAIL back_to_back first=%0d gap=%0d want 17 17",
               first, second - first);
    end
    checks++;
    if (s1 !== 16'h0003 || s2 !== 16'h0007) begin
      errors++;
      $display("FAIL back_to_back_sum s1=%h s2=%h want 0003 0007", s1, s2);
    end
  endtask

  task automatic test_abort();
    int ndone;
    @(negedge clk);
    bus.A = 16'h1234;
    bus.B = 16'h4321;
    bus.Cin = 1'b0;
    bus.Sub = 1'b0;
    bus.Start = 1'b1;
    @(negedge clk);
    bus.Start = 1'b0;
    repeat (7) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.Busy !== 1'b0 || bus.Done !== 1'b0 || bus.Sum !== 16'h0000) begin
      errors++;
      $display("FAIL abort busy=%0b done=%0b sum=%h want 0 0 0000",
               bus.Busy, bus.Done, bus.Sum);
    end
    rst_n = 1'b1;
    ndone = 0;
    for (int k = 0; k < 25; k++) begin
      @(negedge clk);
      if (bus.Done || bus.Busy) ndone++;
    end
    checks++;
    if (ndone !== 0) begin
      errors++;
      $display("FAIL abort_quiet active_cycles=%0d want 0", ndone);
    end
  endtask

  initial begin
    bus.Start = 1'b0;
    bus.A = '0;
    bus.B = '0;
    bus.Cin = 1'b0;
    bus.Sub = 1'b0;
    test_reset();
    test_add();
    test_wrap();
    test_overflow();
    test_cin();
    test_sub();
    test_start_in_run();
    test_back_to_back();
    test_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
